// File: rtl/mem_access_ctrl_if.sv
// Core request/response and single-port RAM bus seen by mem_access_ctrl.
// slave = controller side, master = core/RAM environment side.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 10
) ();
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic              i_req_ind;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_req_wdata;
  logic              o_rsp_valid;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic [DATA_W-1:0] i_ram_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_req_ind, i_req_addr, i_req_wdata, i_ram_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_ram_we, o_ram_addr, o_ram_wdata
  );

  modport master (
    output i_req_valid, i_req_we, i_req_ind, i_req_addr, i_req_wdata, i_ram_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_ram_we, o_ram_addr, o_ram_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-request sequencer to a 1-cycle-latency RAM; response 1/2/3/4 cycles after accept (dir wr/rd, ind wr/rd).
// Accepts only in IDLE (ready low while busy); response is a one-cycle pulse with no backpressure.
module mem_access_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 10
) (
  input logic             clk,
  input logic             rst,
  mem_access_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PTR      = 3'd1;
  localparam logic [2:0] PTR_WAIT = 3'd2;
  localparam logic [2:0] ACC      = 3'd3;
  localparam logic [2:0] RD_WAIT  = 3'd4;

  logic [2:0]        state;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  // RAM address/data only move in PTR and ACC; otherwise they replay the last driven value.
  always_comb begin
    ram_addr  = addr_hold;
    ram_wdata = wdata_hold;
    case (state)
      PTR: ram_addr = lat_addr;
      ACC: begin
        ram_addr  = eff_addr;
        ram_wdata = lat_wdata;
      end
      default: ;
    endcase
  end

  assign bus.o_req_ready = (state == IDLE);
  assign bus.o_ram_addr  = ram_addr;
  assign bus.o_ram_wdata = ram_wdata;
  // Gated by rst so a reset landing in ACC can never corrupt the RAM.
  assign bus.o_ram_we    = rst && (state == ACC) && lat_we;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_data  = rsp_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      eff_addr   <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      addr_hold  <= ram_addr;
      wdata_hold <= ram_wdata;
      rsp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req_valid) begin
            lat_we    <= bus.i_req_we;
            lat_addr  <= bus.i_req_addr;
            lat_wdata <= bus.i_req_wdata;
            eff_addr  <= bus.i_req_addr;
            state     <= bus.i_req_ind ? PTR : ACC;
          end
        end
        PTR: state <= PTR_WAIT;
        PTR_WAIT: begin
          // Only the low address bits of the pointer word are meaningful.
          eff_addr <= bus.i_ram_rdata[ADDR_W-1:0];
          state    <= ACC;
        end
        ACC: begin
          if (lat_we) begin
            rsp_valid <= 1'b1;
            rsp_data  <= lat_wdata;
            state     <= IDLE;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_data  <= bus.i_ram_rdata;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized + directed bench for mem_access_ctrl with a behavioural RAM and a
// transaction-level reference model compared against the DUT every cycle.
module tb_mem_access_ctrl;
  localparam int AW = 6;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Single-port RAM, registered read, write on edge.
  logic [DW-1:0] ram [0:63];
  always @(posedge clk) begin
    if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_wdata;
    bus.i_ram_rdata <= ram[bus.o_ram_addr];
  end

  // Reference model: one outstanding transaction with its accept, access and response cycles.
  int            cyc = 0;
  logic [DW-1:0] mm [0:63];
  bit            exp_ready, exp_rsp_vld, exp_we, exp_addr_vld, exp_acc;
  logic [DW-1:0] exp_rsp_data, exp_wdata;
  logic [AW-1:0] exp_addr;
  bit            pend, p_we, p_ind;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  int            p_acc, p_due;

  always @(posedge clk) begin : model
    bit            acc;
    logic [AW-1:0] e;
    acc = rst && bus.i_req_valid && exp_ready;
    cyc++;
    exp_rsp_vld = 0; exp_we = 0; exp_addr_vld = 0; exp_acc = 0;
    if (!rst) begin
      pend = 0; exp_ready = 1; exp_rsp_data = '0;
    end else begin
      if (pend && cyc == p_due) begin
        e = p_ind ? mm[p_addr][AW-1:0] : p_addr;
        if (p_we) begin
          mm[e] = p_wdata;
          exp_rsp_data = p_wdata;
        end else begin
          exp_rsp_data = mm[e];
        end
        exp_rsp_vld = 1; exp_ready = 1; pend = 0;
      end
      if (acc) begin
        pend = 1; p_we = bus.i_req_we; p_ind = bus.i_req_ind;
        p_addr = bus.i_req_addr; p_wdata = bus.i_req_wdata;
        p_acc = cyc + (p_ind ? 2 : 0);
        p_due = p_acc + (p_we ? 1 : 2);
        exp_ready = 0;
        if (p_ind) begin exp_addr_vld = 1; exp_addr = p_addr; end
      end
      if (pend && cyc == p_acc) begin
        e = p_ind ? mm[p_addr][AW-1:0] : p_addr;
        exp_addr_vld = 1; exp_addr = e;
        exp_acc = 1; exp_we = p_we; exp_wdata = p_wdata;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare();
    chk("req_ready", 32'(bus.o_req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(exp_rsp_vld));
    chk("rsp_data", 32'(bus.o_rsp_data), 32'(exp_rsp_data));
    chk("ram_we", 32'(bus.o_ram_we), 32'(exp_we && rst));
    if (exp_addr_vld) chk("ram_addr", 32'(bus.o_ram_addr), 32'(exp_addr));
    if (exp_acc) chk("ram_wdata", 32'(bus.o_ram_wdata), 32'(exp_wdata));
    if (bus.o_rsp_valid) rsp_cnt++;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic do_req(input bit we, input bit ind, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit jitter, input bit hold,
                        output int k);
    int n;
    n = 0;
    bus.i_req_we = we; bus.i_req_ind = ind; bus.i_req_addr = a; bus.i_req_wdata = d;
    bus.i_req_valid = 1'b1;
    @(negedge clk);
    while (!bus.o_req_ready && n < 30) begin
      if (jitter) begin
        bus.i_req_addr  = AW'($urandom);
        bus.i_req_wdata = DW'($urandom);
      end
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    k = cyc;
    if (!hold) bus.i_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int c, output logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("rsp_timeout", 32'd0, 32'd1);
    c = cyc;
    d = bus.o_rsp_data;
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int k, k1, k2, k3, c, r0;
    logic [DW-1:0] d;
    bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_ind = 1'b0;
    bus.i_req_addr = '0; bus.i_req_wdata = '0;
    fork
      forever begin
        @(negedge clk);
        if (cyc > 0) compare();
      end
    join_none

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.o_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.o_rsp_data), 32'd0);
    chk("rst_ram_we", 32'(bus.o_ram_we), 32'd0);
    step();

    // Fill the whole RAM through the controller
    for (int a = 0; a < 64; a++) do_req(1'b1, 1'b0, AW'(a), DW'($urandom), 1'b0, 1'b0, k);
    repeat (3) step();

    // Direct write then read
    do_req(1'b1, 1'b0, 6'd5, 10'h2A3, 1'b0, 1'b0, k);
    wait_rsp(c, d);
    chk("dw_lat", 32'(c - k), 32'd1);
    chk("dw_data", 32'(d), 32'h2A3);
    do_req(1'b0, 1'b0, 6'd5, 10'h000, 1'b0, 1'b0, k);
    wait_rsp(c, d);
    chk("dr_lat", 32'(c - k), 32'd2);
    chk("dr_data", 32'(d), 32'h2A3);

    // Indirect read: mem[10]=0x3C7 points at 7 (upper bits dropped)
    do_req(1'b1, 1'b0, 6'd10, 10'h3C7, 1'b0, 1'b0, k); wait_rsp(c, d);
    do_req(1'b1, 1'b0, 6'd7, 10'h155, 1'b0, 1'b0, k);  wait_rsp(c, d);
    do_req(1'b0, 1'b1, 6'd10, 10'h000, 1'b0, 1'b0, k);
    chk("ir_ptr_addr", 32'(bus.o_ram_addr), 32'd10);
    step(); step();
    chk("ir_acc_addr", 32'(bus.o_ram_addr), 32'd7);
    wait_rsp(c, d);
    chk("ir_lat", 32'(c - k), 32'd4);
    chk("ir_data", 32'(d), 32'h155);

    // Indirect write through mem[3]=0x014
    do_req(1'b1, 1'b0, 6'd3, 10'h014, 1'b0, 1'b0, k); wait_rsp(c, d);
    do_req(1'b1, 1'b1, 6'd3, 10'h0FF, 1'b0, 1'b0, k);
    chk("iw_we_ptr", 32'(bus.o_ram_we), 32'd0);
    step();
    chk("iw_we_ptrw", 32'(bus.o_ram_we), 32'd0);
    step();
    chk("iw_we_acc", 32'(bus.o_ram_we), 32'd1);
    chk("iw_addr_acc", 32'(bus.o_ram_addr), 32'h14);
    wait_rsp(c, d);
    chk("iw_lat", 32'(c - k), 32'd3);
    chk("iw_data", 32'(d), 32'h0FF);
    do_req(1'b0, 1'b0, 6'h14, 10'h000, 1'b0, 1'b0, k);
    wait_rsp(c, d);
    chk("iw_readback", 32'(d), 32'h0FF);

    // Back-to-back direct reads with valid held high
    r0 = rsp_cnt;
    do_req(1'b0, 1'b0, 6'd1, 10'h000, 1'b0, 1'b1, k1);
    do_req(1'b0, 1'b0, 6'd2, 10'h000, 1'b0, 1'b1, k2);
    do_req(1'b0, 1'b0, 6'd3, 10'h000, 1'b0, 1'b0, k3);
    chk("b2b_gap1", 32'(k2 - k1), 32'd3);
    chk("b2b_gap2", 32'(k3 - k2), 32'd3);
    repeat (5) step();
    chk("b2b_rsp_cnt", 32'(rsp_cnt - r0), 32'd3);

    // Reset during the ACC cycle of a write
    do_req(1'b1, 1'b0, 6'd9, 10'h001, 1'b0, 1'b0, k); wait_rsp(c, d);
    r0 = rsp_cnt;
    do_req(1'b1, 1'b0, 6'd9, 10'h3FF, 1'b0, 1'b0, k);
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_we", 32'(bus.o_ram_we), 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_ready", 32'(bus.o_req_ready), 32'd1);
    step();
    repeat (3) step();
    chk("rstw_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    chk("rstw_mem9", 32'(ram[9]), 32'd1);
    do_req(1'b0, 1'b0, 6'd9, 10'h000, 1'b0, 1'b0, k);
    wait_rsp(c, d);
    chk("rstw_read9", 32'(d), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) step();
      do_req(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
             1'b1, 1'($urandom_range(0, 1)), k);
    end
    bus.i_req_valid = 1'b0;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
